// File: rtl/img_select_scanner.sv
// Cyclic image scanner: steps the 6-input image selector through the requested
// images, showing each for DWELL tick pulses and skipping images whose request drops.
module img_select_scanner #(
  parameter int DWELL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] cond,
  input  logic       tick,
  input  logic       hold,
  output logic [2:0] S,
  output logic       valid,
  output logic       new_img
);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  localparam logic [3:0] LAST = 4'(DWELL - 1);

  state_t     state;
  logic [3:0] count;

  logic [2:0] low_idx;
  logic [2:0] next_idx;
  logic       next_found;
  logic [3:0] sum;
  logic       expiry;

  // Lowest requested index, used when leaving IDLE.
  always_comb begin
    low_idx = '0;
    for (int i = 5; i >= 0; i--) begin
      if (cond[i]) low_idx = 3'(i);
    end
  end

  // First requested index strictly after S in cyclic order (S+1..5, 0..S-1).
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    next_idx   = S;
    next_found = 1'b0;
    sum        = '0;
    for (int i = 5; i >= 1; i--) begin
      sum = {1'b0, S} + 4'(i);
      if (sum >= 4'd6) sum = sum - 4'd6;
      if (cond[sum[2:0]]) begin
        next_idx   = sum[2:0];
        next_found = 1'b1;
      end
    end
  end

  assign expiry = tick && !hold && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      S       <= '0;
      valid   <= 1'b0;
      new_img <= 1'b0;
      count   <= '0;
    end else begin
      new_img <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (cond != 6'd0) begin
            state   <= SHOW;
            S       <= low_idx;
            valid   <= 1'b1;
            new_img <= 1'b1;
          end else begin
            S     <= '0;
            valid <= 1'b0;
          end
        end

        SHOW: begin
          // Request drop-out outranks dwell expiry and ignores hold.
          if (cond == 6'd0) begin
            state <= IDLE;
            S     <= '0;
            valid <= 1'b0;
            count <= '0;
          end else if (!cond[S]) begin
            S       <= next_idx;
            new_img <= 1'b1;
            count   <= '0;
          end else if (expiry) begin
            count <= '0;
            if (next_found) begin
              S       <= next_idx;
              new_img <= 1'b1;
            end
          end else if (tick && !hold) begin
            count <= count + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
          S     <= '0;
          valid <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_select_scanner.sv
// Self-checking bench for img_select_scanner: vector table, directed corner
// sequences, and randomized traffic against a behavioural scanner model.
module tb_img_select_scanner;

  localparam int DWELL = 3;

  logic       clk;
  logic       reset;
  logic [5:0] cond;
  logic       tick;
  logic       hold;
  logic [2:0] S;
  logic       valid;
  logic       new_img;

  int checks;
  int errors;

  // Reference model state: which image is shown, how many ticks it has had.
  bit m_show;
  int m_s;
  int m_cnt;
  bit m_new;

  typedef struct {
    string      name;
    logic [5:0] cond;
    logic       tick;
    logic       hold;
    logic [2:0] s;
    logic       valid;
    logic       new_img;
  } vec_t;

  vec_t vecs[$];

  img_select_scanner #(.DWELL(DWELL)) dut (
    .clk    (clk),
    .reset  (reset),
    .cond   (cond),
    .tick   (tick),
    .hold   (hold),
    .S      (S),
    .valid  (valid),
    .new_img(new_img)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic [5:0] c, input logic t, input logic h);
    cond = c;
    tick = t;
    hold = h;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [2:0] es,
                              input logic ev, input logic en);
    checks++;
    if (S !== es || valid !== ev || new_img !== en) begin
      errors++;
      $display("[TB] FAIL %s: got S=%0d valid=%0b new_img=%0b, want S=%0d valid=%0b new_img=%0b",
               name, S, valid, new_img, es, ev, en);
    end
  endtask

  task automatic do_reset();
    cond  = '0;
    tick  = 1'b0;
    hold  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_state", 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    m_show = 1'b0;
    m_s    = 0;
    m_cnt  = 0;
    m_new  = 1'b0;
  endtask

  // Next requested image after cur, walking forward around the ring of six;
  // returns cur itself when nothing else is requested.
  function automatic int next_after(input logic [5:0] c, input int cur);
    for (int k = 1; k <= 6; k++) begin
      if (c[(cur + k) % 6]) return (cur + k) % 6;
    end
    return cur;
  endfunction

  task automatic model_step(input logic [5:0] c, input logic t, input logic h);
    m_new = 1'b0;
    if (!m_show) begin
      m_cnt = 0;
      m_s   = 0;
      if (c != 0) begin
        m_show = 1'b1;
        m_s    = next_after(c, 5);
        m_new  = 1'b1;
      end
    end else if (c == 0) begin
      m_show = 1'b0;
      m_s    = 0;
      m_cnt  = 0;
    end else if (!c[m_s]) begin
      m_s   = next_after(c, m_s);
      m_new = 1'b1;
      m_cnt = 0;
    end else if (t && !h) begin
      if (m_cnt == DWELL - 1) begin
        int n;
        n     = next_after(c, m_s);
        m_cnt = 0;
        if (n != m_s) begin
          m_s   = n;
          m_new = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    int pulses;
    logic [5:0] rc;
    logic rt;
    logic rh;

    checks = 0;
    errors = 0;
    cond   = '0;
    tick   = 1'b0;
    hold   = 1'b0;
    reset  = 1'b0;

    // Two-image rotation followed by hold/resume and return to IDLE.
    vecs.push_back('{"enter_low",   6'b000101, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{"tick1",       6'b000101, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{"tick2",       6'b000101, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{"expire_to_2", 6'b000101, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1});
    vecs.push_back('{"tick1_s2",    6'b000101, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{"tick2_s2",    6'b000101, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{"wrap_to_0",   6'b000101, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{"no_tick",     6'b000101, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{"cnt1_s0",     6'b000011, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{"held_tick", 6'b000011, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{"resume_cnt2", 6'b000011, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{"resume_exp",  6'b000011, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1});
    vecs.push_back('{"to_idle",     6'b000000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});

    do_reset();
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].cond, vecs[i].tick, vecs[i].hold);
      check_output(vecs[i].name, vecs[i].s, vecs[i].valid, vecs[i].new_img);
    end

    // Quiet idle: no requests, ticks every 4 clocks for 100 clocks.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(6'b000000, (i % 4) == 0, 1'b0);
      check_output("idle_quiet", 3'd0, 1'b0, 1'b0);
    end

    // Single request: one entry pulse, then S stays put across 20 ticks.
    do_reset();
    apply_stimulus(6'b100000, 1'b0, 1'b0);
    check_output("single_entry", 3'd5, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(6'b100000, (i % 2) == 0, 1'b0);
      if (new_img) pulses++;
      check_output("single_hold", 3'd5, 1'b1, 1'b0);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL single_pulses: got %0d extra new_img pulses, want 0", pulses);
    end

    // Drop-out of the shown image together with a tick.
    do_reset();
    apply_stimulus(6'b000101, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(6'b000101, 1'b1, 1'b0);
    check_output("dropout_pre", 3'd2, 1'b1, 1'b1);
    apply_stimulus(6'b000001, 1'b1, 1'b0);
    check_output("dropout_jump", 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(6'b000001, 1'b1, 1'b0);
    check_output("sole_expire", 3'd0, 1'b1, 1'b0);
    apply_stimulus(6'b000101, 1'b1, 1'b0);
    apply_stimulus(6'b000101, 1'b1, 1'b0);
    check_output("cnt_cleared", 3'd0, 1'b1, 1'b0);
    apply_stimulus(6'b000101, 1'b1, 1'b0);
    check_output("cnt_expire", 3'd2, 1'b1, 1'b1);
    apply_stimulus(6'b000101, 1'b0, 1'b1);
    apply_stimulus(6'b000100, 1'b0, 1'b1);
    apply_stimulus(6'b000001, 1'b0, 1'b1);
    check_output("dropout_held", 3'd0, 1'b1, 1'b1);
    apply_stimulus(6'b000000, 1'b0, 1'b0);
    check_output("dropout_idle", 3'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges while S=4, then re-entry.
    do_reset();
    apply_stimulus(6'b010000, 1'b0, 1'b0);
    check_output("s4_entry", 3'd4, 1'b1, 1'b1);
    apply_stimulus(6'b010000, 1'b0, 1'b0);
    check_output("s4_steady", 3'd4, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_output("async_reset", 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("post_reset_entry", 3'd4, 1'b1, 1'b1);

    // Randomized traffic against the model; requests change occasionally so dwell can expire.
    do_reset();
    rc = 6'b000000;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       rc = 6'($urandom);
        1:       rc = rc ^ (6'd1 << $urandom_range(0, 5));
        2:       if ($urandom_range(0, 3) == 0) rc = 6'd0;
        default: ;
      endcase
      rt = ($urandom_range(0, 2) == 0);
      rh = ($urandom_range(0, 4) == 0);
      model_step(rc, rt, rh);
      apply_stimulus(rc, rt, rh);
      check_output("random", 3'(m_s), m_show, m_new);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
